// File: rtl/uart_mmio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_ctrl_pkg
// Brief    : Opcodes, I/O offsets and status bit positions for the UART MMIO block
// Revision : 1.0 - initial release
// ============================================================================
package uart_mmio_ctrl_pkg;

    localparam logic [5:0] c_OP_LB  = 6'h20;
    localparam logic [5:0] c_OP_LW  = 6'h23;
    localparam logic [5:0] c_OP_LBU = 6'h24;
    localparam logic [5:0] c_OP_SB  = 6'h28;
    localparam logic [5:0] c_OP_SW  = 6'h2B;

    localparam logic [27:0] c_OFF_TX_STAT = 28'h00;
    localparam logic [27:0] c_OFF_RX_STAT = 28'h04;
    localparam logic [27:0] c_OFF_TX_DATA = 28'h08;
    localparam logic [27:0] c_OFF_RX_DATA = 28'h0C;
    localparam logic [27:0] c_OFF_CYCLE   = 28'h10;
    localparam logic [27:0] c_OFF_CNT_CLR = 28'h18;

    localparam int c_TXS_READY_BIT = 0;
    localparam int c_TXS_DROP_BIT  = 1;
    localparam int c_RXS_NEMPTY_BIT = 0;
    localparam int c_RXS_OCC_LSB   = 1;
    localparam int c_RXS_OCC_MSB   = 3;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_TX_STAT,
        REG_RX_STAT,
        REG_TX_DATA,
        REG_RX_DATA,
        REG_CYCLE,
        REG_CNT_CLR
    } ioReg_t;

    function automatic ioReg_t decodeReg(input logic [27:0] off);
        case (off)
            c_OFF_TX_STAT: return REG_TX_STAT;
            c_OFF_RX_STAT: return REG_RX_STAT;
            c_OFF_TX_DATA: return REG_TX_DATA;
            c_OFF_RX_DATA: return REG_RX_DATA;
            c_OFF_CYCLE:   return REG_CYCLE;
            c_OFF_CNT_CLR: return REG_CNT_CLR;
            default:       return REG_NONE;
        endcase
    endfunction

    // Occupancy field is only three bits wide, so larger counts pin at 7.
    function automatic logic [2:0] satOcc(input logic [31:0] cnt);
        return (cnt > 32'd7) ? 3'd7 : cnt[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Power-of-two receive FIFO with occupancy count; storage is unreset
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_doPush;
    logic               w_doPop;

    assign full     = (r_count == c_CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign head     = r_mem[r_rdPtr];
    assign w_doPush = push && !full;
    assign w_doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_ctrl
// Brief    : Memory-mapped UART TX/RX, status and cycle counter for the E/M pipe
// Revision : 1.0 - initial release
// ============================================================================
module uart_mmio_ctrl
    import uart_mmio_ctrl_pkg::*;
#(
    parameter int          RX_DEPTH = 4,
    parameter logic [31:0] IO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] addrE,
    input  logic [5:0]  opcodeE,
    input  logic [7:0]  wdataE,
    input  logic        DataInReady,
    input  logic        DataOutValid,
    input  logic [7:0]  UARTDataOut,
    output logic        UARTCtr,
    output logic [31:0] UARTCtrOut,
    output logic        DataInValid,
    output logic [7:0]  TxData,
    output logic        DataOutReady
);

    localparam int c_CNT_W = $clog2(RX_DEPTH) + 1;

    ioReg_t             w_reg;
    logic [27:0]        w_offset;
    logic               w_isLoad;
    logic               w_isStore;
    logic               w_ioLoad;
    logic               w_ioStore;
    logic               w_txFire;
    logic               w_txDrop;
    logic               w_txStatRd;
    logic               w_pop;
    logic               w_push;
    logic               w_clrCnt;
    logic [31:0]        w_rdData;
    logic [31:0]        w_cycleNext;
    logic [7:0]         w_head;
    logic               w_full;
    logic               w_empty;
    logic [c_CNT_W-1:0] w_count;

    logic               r_uartCtr;
    logic [31:0]        r_uartCtrOut;
    logic               r_dataInValid;
    logic [7:0]         r_txData;
    logic               r_txDrop;
    logic [31:0]        r_cycle;

    assign w_offset = addrE[27:0] - IO_BASE[27:0];
    assign w_push   = DataOutValid && !w_full;

    always_comb begin
        w_reg = REG_NONE;
        if (addrE[31:28] == IO_BASE[31:28]) begin
            w_reg = decodeReg(w_offset);
        end
        w_isLoad    = opcodeE inside {c_OP_LB, c_OP_LW, c_OP_LBU};
        w_isStore   = opcodeE inside {c_OP_SB, c_OP_SW};
        w_ioLoad    = !stall && w_isLoad && (w_reg != REG_NONE);
        w_ioStore   = !stall && w_isStore && (w_reg != REG_NONE);
        w_txFire    = w_ioStore && (w_reg == REG_TX_DATA) && DataInReady;
        w_txDrop    = w_ioStore && (w_reg == REG_TX_DATA) && !DataInReady;
        w_txStatRd  = w_ioLoad && (w_reg == REG_TX_STAT);
        w_pop       = w_ioLoad && (w_reg == REG_RX_DATA) && !w_empty;
        w_clrCnt    = w_ioStore && (w_reg == REG_CNT_CLR);
        w_cycleNext = w_clrCnt ? 32'd0 : r_cycle + 32'd1;

        // Counter reads report the value the counter holds during the M cycle.
        w_rdData = '0;
        case (w_reg)
            REG_TX_STAT: begin
                w_rdData[c_TXS_READY_BIT] = DataInReady;
                w_rdData[c_TXS_DROP_BIT]  = r_txDrop;
            end
            REG_RX_STAT: begin
                w_rdData[c_RXS_NEMPTY_BIT]              = !w_empty;
                w_rdData[c_RXS_OCC_MSB:c_RXS_OCC_LSB]   = satOcc(32'(w_count));
            end
            REG_RX_DATA: begin
                if (!w_empty) begin
                    w_rdData[7:0] = w_head;
                end
            end
            REG_CYCLE: begin
                w_rdData = w_cycleNext;
            end
            default: begin
                w_rdData = '0;
            end
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rxFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (w_push),
        .pop    (w_pop),
        .wrData (UARTDataOut),
        .head   (w_head),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_uartCtr     <= 1'b0;
            r_uartCtrOut  <= '0;
            r_dataInValid <= 1'b0;
            r_txData      <= '0;
            r_txDrop      <= 1'b0;
            r_cycle       <= '0;
        end else begin
            r_cycle       <= w_cycleNext;
            r_dataInValid <= w_txFire;
            if (w_txFire) begin
                r_txData <= wdataE;
            end
            if (!stall) begin
                r_uartCtr    <= w_ioLoad;
                r_uartCtrOut <= w_ioLoad ? w_rdData : 32'd0;
                if (w_txDrop) begin
                    r_txDrop <= 1'b1;
                end else if (w_txStatRd) begin
                    r_txDrop <= 1'b0;
                end
            end
        end
    end

    assign UARTCtr      = r_uartCtr;
    assign UARTCtrOut   = r_uartCtrOut;
    assign DataInValid  = r_dataInValid;
    assign TxData       = r_txData;
    assign DataOutReady = !w_full;

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mmio_ctrl
// Brief    : Directed self-checking bench for uart_mmio_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mmio_ctrl;
    import uart_mmio_ctrl_pkg::*;

    localparam logic [31:0] c_BASE  = 32'h8000_0000;
    localparam logic [31:0] c_A_TXS = c_BASE + 32'h00;
    localparam logic [31:0] c_A_RXS = c_BASE + 32'h04;
    localparam logic [31:0] c_A_TXD = c_BASE + 32'h08;
    localparam logic [31:0] c_A_RXD = c_BASE + 32'h0C;
    localparam logic [31:0] c_A_CYC = c_BASE + 32'h10;
    localparam logic [31:0] c_A_CLR = c_BASE + 32'h18;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] addrE;
    logic [5:0]  opcodeE;
    logic [7:0]  wdataE;
    logic        DataInReady;
    logic        DataOutValid;
    logic [7:0]  UARTDataOut;
    logic        UARTCtr;
    logic [31:0] UARTCtrOut;
    logic        DataInValid;
    logic [7:0]  TxData;
    logic        DataOutReady;

    int nChecks = 0;
    int nFails  = 0;

    uart_mmio_ctrl #(
        .RX_DEPTH (4),
        .IO_BASE  (c_BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .addrE        (addrE),
        .opcodeE      (opcodeE),
        .wdataE       (wdataE),
        .DataInReady  (DataInReady),
        .DataOutValid (DataOutValid),
        .UARTDataOut  (UARTDataOut),
        .UARTCtr      (UARTCtr),
        .UARTCtrOut   (UARTCtrOut),
        .DataInValid  (DataInValid),
        .TxData       (TxData),
        .DataOutReady (DataOutReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [5:0] op, input logic [31:0] addr, input logic [7:0] wd);
        opcodeE = op;
        addrE   = addr;
        wdataE  = wd;
        tick();
        opcodeE = 6'h00;
        addrE   = 32'h0;
    endtask

    task automatic readChk(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] exp, input string tag);
        access(op, addr, 8'h00);
        check({tag, "_ctr"}, {31'd0, UARTCtr}, 32'd1);
        check(tag, UARTCtrOut, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        stall        = 1'b0;
        addrE        = 32'h0;
        opcodeE      = 6'h00;
        wdataE       = 8'h00;
        DataInReady  = 1'b1;
        DataOutValid = 1'b0;
        UARTDataOut  = 8'h00;

        #2;
        check("rst_uartctr",  {31'd0, UARTCtr}, 32'd0);
        check("rst_ctrout",   UARTCtrOut, 32'd0);
        check("rst_divalid",  {31'd0, DataInValid}, 32'd0);
        check("rst_txdata",   {24'd0, TxData}, 32'd0);
        check("rst_doready",  {31'd0, DataOutReady}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        readChk(c_OP_LW, c_A_CYC, 32'd1, "cyc_after_rst");
        tick();
        check("idle_uartctr", {31'd0, UARTCtr}, 32'd0);
        check("idle_ctrout",  UARTCtrOut, 32'd0);

        // Three bytes in, three out in order, then empty behaviour
        DataOutValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            UARTDataOut = 8'(8'h41 + i);
            tick();
        end
        DataOutValid = 1'b0;
        readChk(c_OP_LW,  c_A_RXS, 32'h7,  "rxs_three");
        readChk(c_OP_LBU, c_A_RXD, 32'h41, "rxd_0");
        readChk(c_OP_LB,  c_A_RXD, 32'h42, "rxd_1");
        readChk(c_OP_LW,  c_A_RXD, 32'h43, "rxd_2");
        readChk(c_OP_LW,  c_A_RXD, 32'h0,  "rxd_empty");
        readChk(c_OP_LW,  c_A_RXS, 32'h0,  "rxs_empty");

        // Fill to full with a fifth byte waiting
        DataOutValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            UARTDataOut = 8'(8'h11 + i);
            check("dor_filling", {31'd0, DataOutReady}, 32'd1);
            tick();
        end
        UARTDataOut = 8'h15;
        check("dor_full", {31'd0, DataOutReady}, 32'd0);
        tick();
        check("dor_full_hold", {31'd0, DataOutReady}, 32'd0);
        readChk(c_OP_LW, c_A_RXD, 32'h11, "rxd_pop_full");
        check("dor_after_pop", {31'd0, DataOutReady}, 32'd1);
        readChk(c_OP_LW, c_A_RXS, 32'h7, "rxs_no_push_on_pop");
        check("dor_after_fifth", {31'd0, DataOutReady}, 32'd0);
        DataOutValid = 1'b0;
        readChk(c_OP_LW, c_A_RXS, 32'h9, "rxs_full");
        for (int i = 0; i < 4; i++) begin
            readChk(c_OP_LW, c_A_RXD, 32'(32'h12 + i), "rxd_drain");
        end

        // Transmit path and sticky drop flag
        DataInReady = 1'b1;
        access(c_OP_SB, c_A_TXD, 8'h5A);
        check("tx_pulse",  {31'd0, DataInValid}, 32'd1);
        check("tx_data",   {24'd0, TxData}, 32'h5A);
        tick();
        check("tx_one_cycle", {31'd0, DataInValid}, 32'd0);
        readChk(c_OP_LW, c_A_TXS, 32'h1, "txs_ready");
        DataInReady = 1'b0;
        access(c_OP_SB, c_A_TXD, 8'hA5);
        check("tx_dropped",   {31'd0, DataInValid}, 32'd0);
        check("tx_data_kept", {24'd0, TxData}, 32'h5A);
        tick();
        check("tx_no_late", {31'd0, DataInValid}, 32'd0);
        readChk(c_OP_LW, c_A_TXS, 32'h2, "txs_drop");
        readChk(c_OP_LW, c_A_TXS, 32'h0, "txs_cleared");
        access(c_OP_SB, c_A_TXD, 8'h01);
        readChk(c_OP_LW, c_A_TXS, 32'h2, "txs_drop_again");
        access(c_OP_SB, c_A_TXD, 8'h02);
        readChk(c_OP_LW, c_A_TXS, 32'h2, "txs_drop_after_read");
        readChk(c_OP_LW, c_A_TXS, 32'h0, "txs_cleared2");
        DataInReady = 1'b1;

        // Wrong-direction and unmapped accesses
        DataOutValid = 1'b1;
        UARTDataOut  = 8'h66;
        tick();
        DataOutValid = 1'b0;
        access(c_OP_SW, c_A_RXD, 8'h00);
        check("ro_store_ctr", {31'd0, UARTCtr}, 32'd0);
        readChk(c_OP_LW, c_A_TXD, 32'h0, "wo_load_txd");
        readChk(c_OP_LW, c_A_CLR, 32'h0, "wo_load_clr");
        access(c_OP_LW, c_BASE + 32'h14, 8'h00);
        check("unmapped_ctr", {31'd0, UARTCtr}, 32'd0);
        access(c_OP_LW, 32'h0000_000C, 8'h00);
        check("other_region_ctr", {31'd0, UARTCtr}, 32'd0);
        access(c_OP_LW, c_BASE + 32'h0D, 8'h00);
        check("unaligned_ctr", {31'd0, UARTCtr}, 32'd0);
        readChk(c_OP_LW, c_A_RXD, 32'h66, "ro_store_no_pop");
        readChk(c_OP_LW, c_A_RXD, 32'h0,  "rxd_empty2");

        // Counter clear and wrap
        access(c_OP_SW, c_A_CLR, 8'h00);
        readChk(c_OP_LW, c_A_CYC, 32'd1, "cyc_clear");
        readChk(c_OP_LW, c_A_CYC, 32'd2, "cyc_clear_next");
        force dut.r_cycle = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycle;
        readChk(c_OP_LW, c_A_CYC, 32'hFFFF_FFFF, "cyc_max");
        readChk(c_OP_LW, c_A_CYC, 32'h0,         "cyc_wrap");
        readChk(c_OP_LW, c_A_CYC, 32'h1,         "cyc_wrap_next");

        // Stalled RX data load
        DataOutValid = 1'b1;
        UARTDataOut  = 8'h77;
        tick();
        DataOutValid = 1'b0;
        readChk(c_OP_LW, c_A_RXS, 32'h3, "rxs_one");
        stall   = 1'b1;
        opcodeE = c_OP_LW;
        addrE   = c_A_RXD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ctr", {31'd0, UARTCtr}, 32'd1);
            check("stall_out", UARTCtrOut, 32'h3);
        end
        stall = 1'b0;
        tick();
        opcodeE = 6'h00;
        addrE   = 32'h0;
        check("unstall_ctr", {31'd0, UARTCtr}, 32'd1);
        check("unstall_out", UARTCtrOut, 32'h77);
        readChk(c_OP_LW, c_A_RXS, 32'h0, "rxs_after_stall");

        // Reset mid-operation with queued bytes and a live TX pulse
        DataOutValid = 1'b1;
        UARTDataOut  = 8'h01;
        tick();
        UARTDataOut  = 8'h02;
        tick();
        DataOutValid = 1'b0;
        access(c_OP_SB, c_A_TXD, 8'hC3);
        check("pending_pulse", {31'd0, DataInValid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_divalid", {31'd0, DataInValid}, 32'd0);
        check("mid_rst_txdata",  {24'd0, TxData}, 32'd0);
        check("mid_rst_doready", {31'd0, DataOutReady}, 32'd1);
        check("mid_rst_uartctr", {31'd0, UARTCtr}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        check("post_rst_divalid", {31'd0, DataInValid}, 32'd0);
        check("post_rst_doready", {31'd0, DataOutReady}, 32'd1);
        readChk(c_OP_LW, c_A_RXS, 32'h0, "post_rst_rxs");
        readChk(c_OP_LW, c_A_RXD, 32'h0, "post_rst_rxd");
        check("post_rst_no_pulse", {31'd0, DataInValid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_mmio_ctrl.md
UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

Interface
REQ-001 Parameter RX_DEPTH, default 4, sets the receive FIFO entry count; it SHALL be a power of two, at least 2.
REQ-002 Parameter IO_BASE, default 32'h8000_0000, sets the base address of the I/O window.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
  - clk  in  1  rising-edge clock.
  - reset  in  1  asynchronous, active-low reset.
  - stall  in  1  pipeline freeze.
  - addrE  in  32  execute-stage effective address (ALU output).
  - opcodeE  in  6  execute-stage opcode.
  - wdataE  in  8  execute-stage store data, rd2E[7:0].
  - DataInReady  in  1  UART transmitter can accept a byte.
  - DataOutValid  in  1  UART receiver holds a byte.
  - UARTDataOut  in  8  received byte.
  - UARTCtr  out  1  memory-stage load is an I/O read; selects UARTCtrOut for write-back.
  - UARTCtrOut  out  32  I/O read data.
  - DataInValid  out  1  transmit strobe.
  - TxData  out  8  byte to transmit.
  - DataOutReady  out  1  receive FIFO accepts a byte.

Function
REQ-010 The address map SHALL be, from IO_BASE:
  - +0x00 TX status: bit0 = DataInReady; bit1 = sticky tx_drop.
  - +0x04 RX status: bit0 = FIFO not empty; bits[3:1] = occupancy, saturating at 7.
  - +0x08 TX data: write only.
  - +0x0C RX data: read pops the FIFO.
  - +0x10 cycle counter: read only.
  - +0x18 counter clear: write only.
REQ-011 Loads SHALL be opcodes 0x20, 0x23 and 0x24; stores SHALL be 0x28 and 0x2B. An I/O access SHALL require addrE[31:28]==IO_BASE[31:28] and a word offset in the map; other offsets SHALL be ignored.
REQ-012 An access SHALL be decoded in E only while stall==0, and its effects SHALL take place at the next rising edge (the M stage).
REQ-013 UARTCtr SHALL be 1 for exactly the M cycle following a decoded I/O load, with UARTCtrOut valid in that same cycle. Unmapped bits SHALL read 0.
REQ-014 While stall==1, UARTCtr, UARTCtrOut, the FIFO pointers and the tx_drop state SHALL hold their values.
REQ-015 Reading RX data with a non-empty FIFO SHALL return {24'b0, head} and pop one entry; with an empty FIFO it SHALL return 0 and not pop.
REQ-016 DataOutReady SHALL equal the combinational term !full. A push SHALL occur on each edge where DataOutValid && !full.
REQ-017 When the FIFO is full, a pop in a given cycle SHALL NOT enable a push in that same cycle. Push and pop together while not full SHALL leave occupancy unchanged.
REQ-018 FIFO pointers SHALL be log2(RX_DEPTH) bits and wrap modulo RX_DEPTH. Occupancy SHALL be a log2(RX_DEPTH)+1 bit count.
REQ-019 A TX data store while DataInReady==1 SHALL register wdataE into TxData and pulse DataInValid high for exactly one cycle.
REQ-020 A TX data store while DataInReady==0 SHALL be dropped and SHALL set tx_drop. A TX status read SHALL return the pre-clear value and then clear tx_drop.
REQ-021 A drop and a TX status read in the same cycle cannot occur (one access per cycle). A drop occurring in the cycle immediately after such a read SHALL set tx_drop again.
REQ-022 The 32-bit cycle counter SHALL increment every clock, independent of stall, and wrap from 0xFFFF_FFFF to 0.
REQ-023 A decoded store to +0x18 SHALL load the counter with 0 at that edge, overriding the increment. The counter SHALL read 1 one cycle later.
REQ-024 A store to a read-only offset, or a load from a write-only offset, SHALL have no side effect. Such a load SHALL return 0 with UARTCtr=1.

Reset
REQ-030 With reset==0, the block SHALL asynchronously drive UARTCtr=0, UARTCtrOut=0, DataInValid=0, TxData=0, tx_drop=0, FIFO empty (pointers 0, DataOutReady=1) and counter=0.
REQ-031 Reset asserted mid-operation SHALL discard FIFO contents and any pending strobe, with no DataInValid pulse after reset release until a new store.
REQ-032 FIFO storage SHALL NOT need reset.

Structure
REQ-040 A shared package SHALL hold the opcode constants, the six offset constants and the status bit positions.
REQ-041 The receive FIFO SHALL be the sub-module uart_rx_fifo, parameterised by depth and width 8, with push, pop, full, empty and count ports.

Verification
REQ-050 After reset, three bytes 0x41, 0x42, 0x43 are pushed. Reading +0x04 SHALL return 0x7. Three reads of +0x0C SHALL return 0x41, 0x42, 0x43 in order. A fourth read SHALL return 0, and +0x04 SHALL then read 0.
REQ-051 Five bytes are offered with DataOutValid held 1. DataOutReady SHALL fall after the fourth push. The fifth byte SHALL be accepted only on the cycle after the first pop, and never on the pop cycle itself.
REQ-052 sb 0x5A to +0x08 with DataInReady=1 SHALL produce TxData=0x5A and exactly one DataInValid pulse. The same store with DataInReady=0 SHALL produce no pulse, and +0x00 SHALL then read 0x2 followed by 0x0.
REQ-053 The counter is preset near 0xFFFF_FFFE and allowed to wrap; it SHALL read as wrapped. A store to +0x18 at cycle N SHALL make a read at N+1 return 1.
REQ-054 lw of +0x0C with stall=1 for 3 cycles SHALL produce no pop and no UARTCtr change. On release, the byte SHALL appear exactly once.
REQ-055 Reset is asserted with two bytes queued and a TX pulse pending. After release the FIFO SHALL be empty, DataOutReady=1 and DataInValid=0.
